// File: rtl/bram_access_scheduler_if.sv
// bram_access_scheduler_if: PS/PL request channels, job control and shared BRAM port A.
// master = PS/PL/BRAM side driving requests; slave = the scheduler.
interface bram_access_scheduler_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              ps_req, ps_we, ps_gnt, ps_rvalid;
    logic [ADDR_W-1:0] ps_addr;
    logic [DATA_W-1:0] ps_wdata;
    logic              pl_req, pl_we, pl_gnt, pl_rvalid;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_wdata;
    logic              job_start, pl_start, pl_done, busy, timeout_err;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    modport master (
        output ps_req, ps_we, ps_addr, ps_wdata, pl_req, pl_we, pl_addr, pl_wdata, job_start, pl_done,
        input  ps_gnt, ps_rvalid, pl_gnt, pl_rvalid, pl_start, busy, timeout_err, bram_we, bram_addr, bram_wdata
    );
    modport slave (
        input  ps_req, ps_we, ps_addr, ps_wdata, pl_req, pl_we, pl_addr, pl_wdata, job_start, pl_done,
        output ps_gnt, ps_rvalid, pl_gnt, pl_rvalid, pl_start, busy, timeout_err, bram_we, bram_addr, bram_wdata
    );
endinterface

// File: rtl/bram_access_scheduler.sv
// bram_access_scheduler: hands BRAM port A to the PS, or to the PL for one job at a time.
// Define BRAM_TIMEOUT_EN to build the PL-ownership watchdog (TIMEOUT cycles, sticky timeout_err).
module bram_access_scheduler #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input logic                    clk,
    input logic                    rst,
    bram_access_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PS_OWN, START, PL_OWN, RELEASE} state_t;
    state_t            r_state;
    logic              r_job_pending, r_ps_rvalid, r_pl_rvalid;
    logic              w_ps_gnt, w_pl_gnt, w_to_start, w_expire, w_bram_we;
    logic [ADDR_W-1:0] w_bram_addr;
    logic [DATA_W-1:0] w_bram_wdata;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    assign w_ps_gnt     = r_state == PS_OWN && bus.ps_req;
    assign w_pl_gnt     = r_state == PL_OWN && bus.pl_req;
    assign w_to_start   = r_state == PS_OWN && r_job_pending && !bus.ps_req;
    assign w_bram_we    = w_ps_gnt ? bus.ps_we    : w_pl_gnt ? bus.pl_we    : 1'b0;
    assign w_bram_addr  = w_ps_gnt ? bus.ps_addr  : w_pl_gnt ? bus.pl_addr  : '0;
    assign w_bram_wdata = w_ps_gnt ? bus.ps_wdata : w_pl_gnt ? bus.pl_wdata : '0;

    assign bus.ps_gnt     = w_ps_gnt;
    assign bus.pl_gnt     = w_pl_gnt;
    assign bus.bram_we    = w_bram_we;
    assign bus.bram_addr  = w_bram_addr;
    assign bus.bram_wdata = w_bram_wdata;
    assign bus.ps_rvalid  = r_ps_rvalid;
    assign bus.pl_rvalid  = r_pl_rvalid;
    assign bus.pl_start   = r_state == START;
    assign bus.busy       = r_job_pending || r_state == START || r_state == PL_OWN || r_state == RELEASE;

    // A job_start that lands while a job is already pending is simply absorbed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_job_pending <= 1'b0;
            r_ps_rvalid   <= 1'b0;
            r_pl_rvalid   <= 1'b0;
        end else begin
            r_ps_rvalid   <= w_ps_gnt && !bus.ps_we;
            r_pl_rvalid   <= w_pl_gnt && !bus.pl_we;
            r_job_pending <= w_to_start ? 1'b0 : r_job_pending || bus.job_start;
            case (r_state)
                IDLE:    r_state <= PS_OWN;
                PS_OWN:  if (w_to_start) r_state <= START;
                START:   r_state <= PL_OWN;
                PL_OWN:  if (bus.pl_done || w_expire) r_state <= RELEASE;
                default: r_state <= PS_OWN;
            endcase
        end
    end

`ifdef BRAM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wd;
    logic            r_timeout_err;
    // r_wd holds completed PL_OWN cycles, so expiry fires on the TIMEOUT-th one; pl_done wins a tie.
    assign w_expire = r_state == PL_OWN && !bus.pl_done && r_wd == WD_W'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wd          <= r_state == PL_OWN ? r_wd + 1'b1 : '0;
            r_timeout_err <= r_state == START ? 1'b0 : r_timeout_err || w_expire;
        end
    end
    assign bus.timeout_err = r_timeout_err;
`else
    assign w_expire        = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_bram_access_scheduler.sv
// tb_bram_access_scheduler: directed steps with a read-valid scoreboard for bram_access_scheduler.
module tb_bram_access_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] rv_q[$];
    logic       te;

    bram_access_scheduler_if bus ();
    bram_access_scheduler #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one cycle's outputs; the read-valid expectation made now is compared one cycle later.
    task automatic step(input string tag, input logic psg, plg, we, input logic [7:0] addr, wd,
                        input logic st, bz, terr);
        logic [1:0] rv;
        #1;
        rv = rv_q.pop_front();
        chk({tag, " ps_gnt"}, 8'(bus.ps_gnt), 8'(psg));
        chk({tag, " pl_gnt"}, 8'(bus.pl_gnt), 8'(plg));
        chk({tag, " bram_we"}, 8'(bus.bram_we), 8'(we));
        chk({tag, " bram_addr"}, bus.bram_addr, addr);
        chk({tag, " bram_wdata"}, bus.bram_wdata, wd);
        chk({tag, " pl_start"}, 8'(bus.pl_start), 8'(st));
        chk({tag, " busy"}, 8'(bus.busy), 8'(bz));
        chk({tag, " timeout_err"}, 8'(bus.timeout_err), 8'(terr));
        chk({tag, " ps_rvalid"}, 8'(bus.ps_rvalid), 8'(rv[1]));
        chk({tag, " pl_rvalid"}, 8'(bus.pl_rvalid), 8'(rv[0]));
        rv_q.push_back({psg & ~bus.ps_we, plg & ~bus.pl_we});
        @(negedge clk);
    endtask

    initial begin
`ifdef BRAM_TIMEOUT_EN
        te = 1'b1;
`else
        te = 1'b0;
`endif
        bus.ps_req = 0; bus.ps_we = 0; bus.ps_addr = 0; bus.ps_wdata = 0;
        bus.pl_req = 0; bus.pl_we = 0; bus.pl_addr = 0; bus.pl_wdata = 0;
        bus.job_start = 0; bus.pl_done = 0;
        rv_q.push_back(2'b00);
        #2 rst = 1'b0;
        @(negedge clk);
        bus.ps_req = 1; bus.ps_we = 1; bus.ps_addr = 8'h10; bus.ps_wdata = 8'hA5;
        step("rst_a", 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_b", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        step("ps_wr1", 1, 0, 1, 8'h10, 8'hA5, 0, 0, 0);
        step("ps_wr2", 1, 0, 1, 8'h10, 8'hA5, 0, 0, 0);
        bus.ps_we = 0; bus.ps_addr = 8'h22;
        step("ps_rd", 1, 0, 0, 8'h22, 8'hA5, 0, 0, 0);
        bus.ps_req = 0;
        step("ps_rv", 0, 0, 0, 0, 0, 0, 0, 0);
        step("ps_rv_end", 0, 0, 0, 0, 0, 0, 0, 0);
        bus.pl_req = 1; bus.pl_we = 1; bus.pl_addr = 8'h05; bus.pl_wdata = 8'h3C;
        step("pl_in_ps", 0, 0, 0, 0, 0, 0, 0, 0);
        bus.pl_req = 0; bus.ps_req = 1; bus.ps_we = 1; bus.ps_addr = 8'h10; bus.job_start = 1;
        step("job_req", 1, 0, 1, 8'h10, 8'hA5, 0, 0, 0);
        bus.job_start = 0;
        step("job_hold1", 1, 0, 1, 8'h10, 8'hA5, 0, 1, 0);
        step("job_hold2", 1, 0, 1, 8'h10, 8'hA5, 0, 1, 0);
        bus.ps_req = 0;
        step("job_wait", 0, 0, 0, 0, 0, 0, 1, 0);
        bus.pl_req = 1;
        step("start", 0, 0, 0, 0, 0, 1, 1, 0);
        step("pl_wr", 0, 1, 1, 8'h05, 8'h3C, 0, 1, 0);
        bus.pl_we = 0; bus.job_start = 1;
        step("pl_rd", 0, 1, 0, 8'h05, 8'h3C, 0, 1, 0);
        bus.pl_req = 0; bus.ps_req = 1; bus.job_start = 0;
        step("ps_in_pl", 0, 0, 0, 0, 0, 0, 1, 0);
        bus.job_start = 1;
        step("ps_in_pl2", 0, 0, 0, 0, 0, 0, 1, 0);
        bus.job_start = 0; bus.pl_done = 1;
        step("pl_done", 0, 0, 0, 0, 0, 0, 1, 0);
        bus.pl_done = 0; bus.job_start = 1;
        step("release", 0, 0, 0, 0, 0, 0, 1, 0);
        bus.job_start = 0;
        step("ps_back", 1, 0, 1, 8'h10, 8'hA5, 0, 1, 0);
        bus.ps_req = 0; bus.pl_req = 1; bus.pl_we = 1;
        step("job2_wait", 0, 0, 0, 0, 0, 0, 1, 0);
        step("job2_start", 0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step("wd_own", 0, 1, 1, 8'h05, 8'h3C, 0, 1, 0);
`ifdef BRAM_TIMEOUT_EN
        step("wd_rel", 0, 0, 0, 0, 0, 0, 1, 1);
        step("wd_ps", 0, 0, 0, 0, 0, 0, 0, 1);
`else
        for (int i = 0; i < 4; i++) step("wd_stay", 0, 1, 1, 8'h05, 8'h3C, 0, 1, 0);
        bus.pl_done = 1;
        step("done2", 0, 1, 1, 8'h05, 8'h3C, 0, 1, 0);
        bus.pl_done = 0;
        step("rel2", 0, 0, 0, 0, 0, 0, 1, 0);
        step("ps2", 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        bus.pl_req = 0; bus.pl_done = 1;
        step("done_ignored", 0, 0, 0, 0, 0, 0, 0, te);
        bus.pl_done = 0; bus.job_start = 1;
        step("job3_req", 0, 0, 0, 0, 0, 0, 0, te);
        bus.job_start = 0;
        step("job3_wait", 0, 0, 0, 0, 0, 0, 1, te);
        step("job3_start", 0, 0, 0, 0, 0, 1, 1, te);
        bus.pl_req = 1;
        step("job3_own", 0, 1, 1, 8'h05, 8'h3C, 0, 1, 0);
        rst = 1'b0;
        step("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step("post_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        step("post_ps1", 0, 0, 0, 0, 0, 0, 0, 0);
        step("post_ps2", 0, 0, 0, 0, 0, 0, 0, 0);
        bus.ps_req = 1;
        step("post_gnt", 1, 0, 1, 8'h10, 8'hA5, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
